// File: rtl/time_counter_bcd.sv
// Time-of-day counter for the alarm clock datapath.
// Keeps a 24-hour binary count (hours/minutes/optional seconds), advances on
// a one-cycle tick, accepts validated loads, and drives a registered BCD
// display word (24-hour or 12-hour with pm flag) that tracks the count with
// no extra latency.
module time_counter_bcd #(
  parameter int unsigned HOUR_12     = 0,
  parameter int unsigned HAS_SECONDS = 0,
  localparam int unsigned DISP_W     = (HAS_SECONDS != 32'd0) ? 24 : 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              hold,
  input  logic              set_time,
  input  logic [4:0]        new_time_hr,
  input  logic [5:0]        new_time_min,
  input  logic [5:0]        new_time_sec,
  output logic [4:0]        hours,
  output logic [5:0]        minutes,
  output logic [5:0]        seconds,
  output logic [DISP_W-1:0] display_value,
  output logic              pm,
  output logic              day_wrap,
  output logic              load_err
);

  // Display word shown straight out of reset: 00:00 in 24-hour mode, 12:00 AM in 12-hour mode.
  localparam logic [DISP_W-1:0] DISP_RST = (HOUR_12 != 32'd0) ?
                                           {8'h12, {(DISP_W-8){1'b0}}} :
                                           {DISP_W{1'b0}};

  // Two-digit BCD of a binary value in 0..59.
  function automatic logic [7:0] bcd8(input logic [5:0] v);
    return {4'(v / 6'd10), 4'(v % 6'd10)};
  endfunction

  logic [4:0]        hours_r;
  logic [5:0]        minutes_r;
  logic [5:0]        seconds_r;
  logic [DISP_W-1:0] display_r;
  logic              pm_r;
  logic              day_wrap_r;
  logic              load_err_r;

  logic [4:0]        hours_nxt_s;
  logic [5:0]        minutes_nxt_s;
  logic [5:0]        seconds_nxt_s;
  logic              day_wrap_nxt_s;
  logic              load_err_nxt_s;
  logic              load_ok_s;
  logic              sec_at_max_s;
  logic              min_at_max_s;
  logic              hr_at_max_s;
  logic [4:0]        hr_disp_s;
  logic [DISP_W-1:0] disp_nxt_s;
  logic              pm_nxt_s;

  // Qualify the load fields; out-of-range values never reach the counters.
  always_comb begin
    load_ok_s    = (new_time_hr <= 5'd23) && (new_time_min <= 6'd59) &&
                   ((HAS_SECONDS == 32'd0) || (new_time_sec <= 6'd59));
    // Without a seconds field every tick is a minute, so seconds are always "at max".
    sec_at_max_s = (HAS_SECONDS == 32'd0) || (seconds_r == 6'd59);
    min_at_max_s = (minutes_r == 6'd59);
    hr_at_max_s  = (hours_r == 5'd23);
  end

  // Next count: reset is handled in the register, then load beats tick; a tick during a load is dropped.
  always_comb begin
    hours_nxt_s    = hours_r;
    minutes_nxt_s  = minutes_r;
    seconds_nxt_s  = seconds_r;
    day_wrap_nxt_s = 1'b0;
    load_err_nxt_s = 1'b0;
    if (set_time) begin
      if (load_ok_s) begin
        hours_nxt_s   = new_time_hr;
        minutes_nxt_s = new_time_min;
        seconds_nxt_s = (HAS_SECONDS != 32'd0) ? new_time_sec : 6'd0;
      end else begin
        load_err_nxt_s = 1'b1;
      end
    end else if (tick && !hold) begin
      seconds_nxt_s = sec_at_max_s ? 6'd0 : (seconds_r + 6'd1);
      if (sec_at_max_s) begin
        if (min_at_max_s) begin
          minutes_nxt_s = 6'd0;
          hours_nxt_s   = hr_at_max_s ? 5'd0 : (hours_r + 5'd1);
        end else begin
          minutes_nxt_s = minutes_r + 6'd1;
        end
      end else begin
        minutes_nxt_s = minutes_r;
      end
      day_wrap_nxt_s = sec_at_max_s && min_at_max_s && hr_at_max_s;
    end else begin
      day_wrap_nxt_s = 1'b0;
    end
  end

  // Hour digits for the display: 12-hour mode maps 0 -> 12 and 13..23 -> 1..11.
  always_comb begin
    hr_disp_s = hours_nxt_s;
    if (HOUR_12 != 32'd0) begin
      if (hours_nxt_s == 5'd0) begin
        hr_disp_s = 5'd12;
      end else if (hours_nxt_s > 5'd12) begin
        hr_disp_s = hours_nxt_s - 5'd12;
      end else begin
        hr_disp_s = hours_nxt_s;
      end
    end else begin
      hr_disp_s = hours_nxt_s;
    end
    pm_nxt_s = (HOUR_12 != 32'd0) && (hours_nxt_s >= 5'd12);
  end

  if (HAS_SECONDS != 32'd0) begin : g_with_sec
    assign disp_nxt_s = {bcd8({1'b0, hr_disp_s}), bcd8(minutes_nxt_s), bcd8(seconds_nxt_s)};
  end else begin : g_no_sec
    assign disp_nxt_s = {bcd8({1'b0, hr_disp_s}), bcd8(minutes_nxt_s)};
  end

  // Register the count and its display together so every output changes on the accepting edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      hours_r    <= 5'd0;
      minutes_r  <= 6'd0;
      seconds_r  <= 6'd0;
      display_r  <= DISP_RST;
      pm_r       <= 1'b0;
      day_wrap_r <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      hours_r    <= hours_nxt_s;
      minutes_r  <= minutes_nxt_s;
      seconds_r  <= seconds_nxt_s;
      display_r  <= disp_nxt_s;
      pm_r       <= pm_nxt_s;
      day_wrap_r <= day_wrap_nxt_s;
      load_err_r <= load_err_nxt_s;
    end
  end

  assign hours         = hours_r;
  assign minutes       = minutes_r;
  assign seconds       = seconds_r;
  assign display_value = display_r;
  assign pm            = pm_r;
  assign day_wrap      = day_wrap_r;
  assign load_err      = load_err_r;

endmodule

// File: doc/time_counter_bcd.md
# time_counter_bcd

Parametrised time-of-day counter for the alarm clock datapath. It replaces the event-driven minute counter with a single-clock design. It advances on a one-cycle `tick` enable from the timing generator and supports optional seconds, 12/24-hour display mode, validated time loads, a hold input, and a day-rollover pulse. Its outputs feed the display driver (BCD) and the alarm comparator (binary).

## Interface
- HOUR_12, default 0: display mode. 0 = 24-hour display (00–23). 1 = 12-hour display (12, 01–11 plus `pm` flag). Internal count is always 24-hour.
- HAS_SECONDS, default 0: 1 = seconds field present and `tick` means one second. 0 = `tick` means one minute.
- Derived localparam DISP_W = HAS_SECONDS ? 24 : 16.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high
- tick  in  1  one-cycle advance enable (second or minute per HAS_SECONDS)
- hold  in  1  while high, `tick` is ignored; loads are still accepted
- set_time  in  1  one-cycle load strobe
- new_time_hr  in  5  load hours, 24-hour binary, 0–23
- new_time_min  in  6  load minutes, 0–59
- new_time_sec  in  6  load seconds, 0–59; ignored when HAS_SECONDS=0
- hours  out  5  binary hours 0–23
- minutes  out  6  binary minutes 0–59
- seconds  out  6  binary seconds 0–59; constant 0 when HAS_SECONDS=0
- display_value  out  DISP_W  BCD digits, MSB first:
  - HAS_SECONDS=1: [23:20] hr tens, [19:16] hr units, [15:12] min tens, [11:8] min units, [7:4] sec tens, [3:0] sec units
  - HAS_SECONDS=0: [15:12] hr tens, [11:8] hr units, [7:4] min tens, [3:0] min units
- pm  out  1  1 when hours ≥ 12 and HOUR_12=1; always 0 when HOUR_12=0
- day_wrap  out  1  one-cycle pulse on tick-driven rollover to 00:00(:00)
- load_err  out  1  one-cycle pulse when a `set_time` load is rejected

## Operation
- Reset values: hours/minutes/seconds = 0, day_wrap = 0, load_err = 0.
- Reset value of display_value:
  - HOUR_12=0: all zeros (00:00).
  - HOUR_12=1: 12:00 AM, i.e. 16'h1200 or 24'h120000; pm = 0.
- Priority, evaluated each cycle: reset > set_time > (tick & ~hold). A tick that coincides with a load is dropped; it is not deferred.
- Load:
  - Valid when hr ≤ 23, min ≤ 59, and (if HAS_SECONDS) sec ≤ 59. A valid load writes all fields; when HAS_SECONDS=0, seconds stay 0.
  - Invalid load: no field changes and load_err pulses for one cycle. Partial loads never occur.
- Tick, cascade:
  - If HAS_SECONDS, seconds increment; 59 → 0 carries into minutes.
  - Minutes 59 → 0 carries into hours.
  - Hours 23 → 0 on carry.
  - day_wrap = 1 exactly when all fields were at their maximum (23:59 or 23:59:59) and the tick was accepted.
- Display conversion (BCD tens = value / 10, units = value % 10, over binary outputs):
  - HOUR_12=1, hour digits: hours 0 → 12; 1–12 → as-is; 13–23 → hours − 12.
  - pm = (hours ≥ 12).
  - Minutes and seconds digits are identical in both modes.
- hold does not affect reset or load. A held counter shows a static value.
- Inputs outside the declared ranges (e.g. hr = 31) are always rejected. They must never reach the counters.

## Timing
- Zero-cycle latency from the accepting edge. hours/minutes/seconds, display_value, pm, day_wrap and load_err are all registered and updated on the same rising edge that samples tick/set_time.
- day_wrap and load_err are high for exactly one cycle, then return to 0 on the next edge unless re-triggered.
- Back-to-back ticks on consecutive cycles must each advance the count; there is no minimum tick spacing.
- Reset asserted mid-cascade (same edge as a rollover tick) yields the reset values, with day_wrap = 0.
- display_value must never show a non-BCD nibble (> 9) or an out-of-range time in any cycle after reset.

## Test plan
- HAS_SECONDS=0, HOUR_12=0:
  - Reset, then 61 ticks → hours=1, minutes=1, display_value=16'h0101.
  - Load 23:59, 1 tick → 00:00 with day_wrap high for one cycle.
- HAS_SECONDS=1: load 12:59:59, tick → 13:00:00 and display 24'h130000. With HOUR_12=1 the same sequence gives display 24'h010000 and pm=1.
- HOUR_12=1, walk hours:
  - Load 00:00 → display 16'h1200, pm=0.
  - Load 12:05 → 16'h1205, pm=1.
  - Load 23:45 → 16'h1145, pm=1.
- Invalid loads:
  - From 10:30, set_time with hr=24, min=0 → load_err pulses, time stays 10:30.
  - hr=5, min=60 → load_err pulses, time unchanged.
- Simultaneous and held events:
  - set_time (08:15) with tick in the same cycle → 08:15, not 08:16.
  - hold=1 with 5 ticks → no change.
  - hold=1 with set_time → load accepted.
  - reset with set_time → 00:00.
